// File: rtl/cnn_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_stream_pkg
// Purpose  : Shared constants and FSM state type for cnn_frame_streamer.
//            Macro CNN_STREAM_CHECKSUM_EN adds a 2-byte pixel checksum.
// Revision : 1.0
// ============================================================================
package cnn_stream_pkg;

  localparam int IMG_WIDTH   = 32;
  localparam int IMG_HEIGHT  = 32;
  localparam int IMG_SIZE    = IMG_WIDTH * IMG_HEIGHT;
  localparam int RESULT_W    = 48;
  localparam int TIMEOUT_CYC = 50000;

`ifdef CNN_STREAM_CHECKSUM_EN
  localparam int TX_BYTES = RESULT_W / 8 + 2;
`else
  localparam int TX_BYTES = RESULT_W / 8;
`endif

  localparam logic [RESULT_W-1:0] SENTINEL_RESULT = {1'b1, {(RESULT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    START    = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    SEND     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_frame_streamer_ram.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_ram
// Purpose  : Simple dual-port frame RAM, synchronous write, 1-cycle read.
// Revision : 1.0
// ============================================================================
module frame_buffer_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/cnn_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_streamer
// Purpose  : Buffers a host frame, streams it to CNN_TOP, returns the result
//            bytes to the host. Optional macro: CNN_STREAM_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module cnn_frame_streamer
  import cnn_stream_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                host_rx_valid,
  output logic                host_rx_ready,
  input  logic [7:0]          host_rx_data,
  output logic                start_signal,
  output logic                pixel_valid,
  output logic [7:0]          pixel_in,
  input  logic                final_result_valid,
  input  logic [RESULT_W-1:0] final_lane_result,
  output logic                host_tx_valid,
  input  logic                host_tx_ready,
  output logic [7:0]          host_tx_data,
  output logic                busy,
  output logic                timeout_err
);

  localparam int c_aw    = $clog2(IMG_SIZE);
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC);
  localparam int c_tx_w  = TX_BYTES * 8;
  localparam int c_idx_w = $clog2(TX_BYTES);

  localparam logic [c_aw-1:0]    c_wr_last  = c_aw'(IMG_SIZE - 1);
  localparam logic [c_aw:0]      c_rd_end   = (c_aw + 1)'(IMG_SIZE);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(TX_BYTES - 1);

  state_t              r_state;
  logic [c_aw-1:0]     r_wr_cnt;
  logic [c_aw:0]       r_rd_cnt;
  logic [c_tmo_w-1:0]  r_tmo_cnt;
  logic [c_tx_w-1:0]   r_tx_shift;
  logic [c_idx_w-1:0]  r_tx_idx;
  logic                r_rx_ready;
  logic                r_start;
  logic                r_pix_valid;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_timeout_err;

  logic                w_wr_en;
  logic                w_rd_en;
  logic [7:0]          w_rd_data;
  logic [RESULT_W-1:0] w_result;
  logic [c_tx_w-1:0]   w_tx_load;

  assign w_wr_en  = host_rx_valid && r_rx_ready;
  assign w_rd_en  = (r_state == START) || ((r_state == STREAM) && (r_rd_cnt != c_rd_end));
  // A real result in the timeout cycle takes priority over the sentinel.
  assign w_result = final_result_valid ? final_lane_result : SENTINEL_RESULT;

  frame_buffer_ram #(
    .DEPTH (IMG_SIZE),
    .DW    (8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_cnt),
    .wr_data (host_rx_data),
    .rd_en   (w_rd_en),
    .rd_addr (r_rd_cnt[c_aw-1:0]),
    .rd_data (w_rd_data)
  );

`ifdef CNN_STREAM_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= 16'h0000;
    end else if (r_state == START) begin
      r_csum <= 16'h0000;
    end else if (r_pix_valid) begin
      r_csum <= r_csum + {8'h00, w_rd_data};
    end
  end

  assign w_tx_load = {w_result, r_csum};
`else
  assign w_tx_load = w_result;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= LOAD;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_tmo_cnt     <= '0;
      r_tx_shift    <= '0;
      r_tx_idx      <= '0;
      r_rx_ready    <= 1'b1;
      r_start       <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_wr_en) begin
            if (r_wr_cnt == '0) r_timeout_err <= 1'b0;
            if (r_wr_cnt == c_wr_last) begin
              r_wr_cnt   <= '0;
              r_rx_ready <= 1'b0;
              r_start    <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= START;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        START: begin
          r_rd_cnt    <= (c_aw + 1)'(1);
          r_pix_valid <= 1'b1;
          r_state     <= STREAM;
        end
        STREAM: begin
          // r_rd_cnt runs one address ahead of the pixel on pixel_in.
          if (r_rd_cnt == c_rd_end) begin
            r_rd_cnt    <= '0;
            r_pix_valid <= 1'b0;
            r_tmo_cnt   <= '0;
            r_state     <= WAIT_RES;
          end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        WAIT_RES: begin
          if (final_result_valid || (r_tmo_cnt == c_tmo_last)) begin
            r_tx_shift <= w_tx_load;
            r_tx_idx   <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= SEND;
            if (!final_result_valid) r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        SEND: begin
          if (host_tx_ready) begin
            r_tx_shift <= {r_tx_shift[c_tx_w-9:0], 8'h00};
            if (r_tx_idx == c_idx_last) begin
              r_tx_valid <= 1'b0;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= LOAD;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign host_rx_ready = r_rx_ready;
  assign start_signal  = r_start;
  assign pixel_valid   = r_pix_valid;
  assign pixel_in      = r_pix_valid ? w_rd_data : 8'h00;
  assign host_tx_valid = r_tx_valid;
  assign host_tx_data  = r_tx_shift[c_tx_w-1 -: 8];
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire
